// File: rtl/dram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dram_pkg
// Description : Shared types, constants and the address range check for the
//               byte-addressed DRAM model.
// Revision    : 1.0 - initial release
// ============================================================================
package dram_pkg;

  typedef logic [7:0] byte_t;

  localparam int DRAM_DEFAULT_LANES = 4;

  // True when every byte of an access (addr .. addr+lanes-1) lies inside the
  // array. The sum is formed one bit wider than the operands so an address
  // near the top of the address space cannot wrap back into range.
  function automatic logic in_range(input logic [63:0] addr,
                                    input logic [63:0] lanes,
                                    input logic [63:0] depth);
    logic [64:0] w_last;
    w_last = {1'b0, addr} + {1'b0, lanes} - 65'd1;
    return (w_last < {1'b0, depth});
  endfunction

endpackage
`default_nettype wire

// File: rtl/dram_rd_pipe.sv
`default_nettype none
// ============================================================================
// Module      : dram_rd_pipe
// Description : {valid, data} delay line of STAGES registers (STAGES >= 1).
//               Data registers only load on a valid beat, so the output data
//               holds the last returned word while out_valid is low.
// Ports       : clk, rst      - clock, synchronous active-high reset
//               in_valid/data - beat entering the line
//               out_valid/data- beat leaving the line STAGES cycles later
// Revision    : 1.0 - initial release
// ============================================================================
module dram_rd_pipe #(
  parameter int STAGES = 1,
  parameter int WIDTH  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  logic [STAGES-1:0] r_valid;
  logic [WIDTH-1:0]  r_data [0:STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
      for (int i = 0; i < STAGES; i++) begin
        r_data[i] <= '0;
      end
    end else begin
      r_valid[0] <= in_valid;
      if (in_valid) begin
        r_data[0] <= in_data;
      end
      for (int i = 1; i < STAGES; i++) begin
        r_valid[i] <= r_valid[i-1];
        if (r_valid[i-1]) begin
          r_data[i] <= r_data[i-1];
        end
      end
    end
  end

  assign out_valid = r_valid[STAGES-1];
  assign out_data  = r_data[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/dram_byte_mem.sv
`default_nettype none
// ============================================================================
// Module      : dram_byte_mem
// Description : Byte-addressed little-endian memory with LANES bytes per
//               access, per-byte write strobes, a READ_LATENCY-deep read
//               pipeline, sticky out-of-range flag and access counters.
//               The storage array `mem` is not reset so preloads survive rst.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               dram_re / dram_we   - read / write request
//               dram_wstrb          - byte enables, bit i -> addr+i
//               dram_addr           - byte address (unaligned allowed)
//               dram_w_data         - write data, byte i in [8i+7:8i]
//               dram_r_data         - read data (held while not valid)
//               dram_r_valid        - one pulse per returned read
//               err_oob             - sticky out-of-range access flag
//               rd_count / wr_count - accepted in-range reads / writes
// Revision    : 1.0 - initial release
// ============================================================================
module dram_byte_mem
  import dram_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int LANES        = DRAM_DEFAULT_LANES,
  parameter int DEPTH_BYTES  = 20001,
  parameter int READ_LATENCY = 1,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  dram_re,
  input  logic                  dram_we,
  input  logic [LANES-1:0]      dram_wstrb,
  input  logic [ADDR_WIDTH-1:0] dram_addr,
  input  logic [8*LANES-1:0]    dram_w_data,
  output logic [8*LANES-1:0]    dram_r_data,
  output logic                  dram_r_valid,
  output logic                  err_oob,
  output logic [CNT_WIDTH-1:0]  rd_count,
  output logic [CNT_WIDTH-1:0]  wr_count
);

  localparam int c_DW    = 8 * LANES;
  localparam int c_IDX_W = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;

  byte_t mem [0:DEPTH_BYTES-1];

  logic               w_in_range;
  logic [c_IDX_W-1:0] w_base;
  logic [c_DW-1:0]    w_rd_word;

  logic               r_s0_valid;
  logic [c_DW-1:0]    r_s0_data;
  logic               r_err_oob;
  logic [CNT_WIDTH-1:0] r_rd_count;
  logic [CNT_WIDTH-1:0] r_wr_count;

  assign w_in_range = in_range(64'(dram_addr), 64'(LANES), 64'(DEPTH_BYTES));

  // Only the low index bits are needed: the array is only touched when the
  // whole access is in range, so the upper address bits are zero then.
  assign w_base = dram_addr[c_IDX_W-1:0];

  always_comb begin
    w_rd_word = '0;
    if (w_in_range) begin
      for (int i = 0; i < LANES; i++) begin
        w_rd_word[8*i +: 8] = mem[w_base + c_IDX_W'(i)];
      end
    end
  end

  // Non-blocking update means a same-edge read sees the pre-write bytes.
  always_ff @(posedge clk) begin
    if (!rst && dram_we && w_in_range) begin
      for (int i = 0; i < LANES; i++) begin
        if (dram_wstrb[i]) begin
          mem[w_base + c_IDX_W'(i)] <= dram_w_data[8*i +: 8];
        end
      end
    end
  end

  // Stage 0: array lookup (zero for out-of-range), plus flag and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s0_valid <= 1'b0;
      r_s0_data  <= '0;
      r_err_oob  <= 1'b0;
      r_rd_count <= '0;
      r_wr_count <= '0;
    end else begin
      r_s0_valid <= dram_re;
      if (dram_re) begin
        r_s0_data <= w_rd_word;
      end
      if ((dram_re || dram_we) && !w_in_range) begin
        r_err_oob <= 1'b1;
      end
      if (dram_re && w_in_range) begin
        r_rd_count <= r_rd_count + 1'b1;
      end
      if (dram_we && w_in_range) begin
        r_wr_count <= r_wr_count + 1'b1;
      end
    end
  end

  generate
    if (READ_LATENCY <= 1) begin : g_direct
      assign dram_r_valid = r_s0_valid;
      assign dram_r_data  = r_s0_data;
    end else begin : g_pipe
      dram_rd_pipe #(
        .STAGES (READ_LATENCY - 1),
        .WIDTH  (c_DW)
      ) u_rd_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (r_s0_valid),
        .in_data   (r_s0_data),
        .out_valid (dram_r_valid),
        .out_data  (dram_r_data)
      );
    end
  endgenerate

  assign err_oob  = r_err_oob;
  assign rd_count = r_rd_count;
  assign wr_count = r_wr_count;

endmodule
`default_nettype wire

// File: tb/tb_dram_byte_mem.sv
`default_nettype none
// ============================================================================
// Module      : tb_dram_byte_mem
// Description : Directed self-checking bench. dut runs READ_LATENCY=1,
//               dut3 runs READ_LATENCY=3; both use the default geometry.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dram_byte_mem;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic        re1 = 0, we1 = 0;
  logic [3:0]  wstrb1 = 0;
  logic [31:0] addr1 = 0, wdata1 = 0;
  logic [31:0] rdata1;
  logic        rvalid1, err1;
  logic [31:0] rdcnt1, wrcnt1;

  logic        re3 = 0, we3 = 0;
  logic [3:0]  wstrb3 = 0;
  logic [31:0] addr3 = 0, wdata3 = 0;
  logic [31:0] rdata3;
  logic        rvalid3, err3;
  logic [31:0] rdcnt3, wrcnt3;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dram_byte_mem #(.READ_LATENCY(1)) dut (
    .clk(clk), .rst(rst), .dram_re(re1), .dram_we(we1), .dram_wstrb(wstrb1),
    .dram_addr(addr1), .dram_w_data(wdata1), .dram_r_data(rdata1),
    .dram_r_valid(rvalid1), .err_oob(err1), .rd_count(rdcnt1), .wr_count(wrcnt1)
  );

  dram_byte_mem #(.READ_LATENCY(3)) dut3 (
    .clk(clk), .rst(rst), .dram_re(re3), .dram_we(we3), .dram_wstrb(wstrb3),
    .dram_addr(addr3), .dram_w_data(wdata3), .dram_r_data(rdata3),
    .dram_r_valid(rvalid3), .err_oob(err3), .rd_count(rdcnt3), .wr_count(wrcnt3)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic preload();
    dut.mem[100] = 8'h11; dut.mem[101] = 8'h22;
    dut.mem[102] = 8'h33; dut.mem[103] = 8'h44;
    for (int i = 0; i < 4; i++) begin
      dut.mem[200 + i] = 8'h00;
      dut.mem[300 + i] = 8'h00;
    end
    dut.mem[19997] = 8'h59; dut.mem[19998] = 8'h5A;
    dut.mem[19999] = 8'h5B; dut.mem[20000] = 8'h5C;
    for (int i = 0; i < 12; i++) dut3.mem[i] = 8'(i + 1);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
    n_checks++;
    if ({rdata1, rvalid1, err1, rdcnt1, wrcnt1} !== 98'd0) begin
      n_fail++;
      $display("FAIL reset_lat1: got data=%h v=%b err=%b rd=%0d wr=%0d, want all zero",
               rdata1, rvalid1, err1, rdcnt1, wrcnt1);
    end
    n_checks++;
    if ({rdata3, rvalid3, err3, rdcnt3, wrcnt3} !== 98'd0) begin
      n_fail++;
      $display("FAIL reset_lat3: got data=%h v=%b err=%b rd=%0d wr=%0d, want all zero",
               rdata3, rvalid3, err3, rdcnt3, wrcnt3);
    end
  endtask

  task automatic test_read();
    re1 = 1; addr1 = 100;
    cyc();
    re1 = 0;
    n_checks++;
    if (rdata1 !== 32'h44332211 || rvalid1 !== 1'b1 || rdcnt1 !== 32'd1) begin
      n_fail++;
      $display("FAIL read_basic: got data=%h v=%b rd=%0d, want 44332211 v=1 rd=1",
               rdata1, rvalid1, rdcnt1);
    end
    cyc();
    n_checks++;
    if (rdata1 !== 32'h44332211 || rvalid1 !== 1'b0) begin
      n_fail++;
      $display("FAIL read_hold: got data=%h v=%b, want 44332211 v=0", rdata1, rvalid1);
    end
  endtask

  // wstrb 0101 at 101 writes byte0 (DD) to 101 and byte2 (BB) to 103,
  // so mem[100..103] becomes 11,DD,33,BB.
  task automatic test_strobe_write();
    we1 = 1; addr1 = 101; wstrb1 = 4'b0101; wdata1 = 32'hAABBCCDD;
    cyc();
    we1 = 0;
    n_checks++;
    if (wrcnt1 !== 32'd1) begin
      n_fail++;
      $display("FAIL strobe_wr_count: got %0d, want 1", wrcnt1);
    end
    re1 = 1; addr1 = 100;
    cyc();
    re1 = 0;
    n_checks++;
    if (rdata1 !== 32'hBB33DD11 || rvalid1 !== 1'b1 || rdcnt1 !== 32'd2) begin
      n_fail++;
      $display("FAIL strobe_readback: got data=%h v=%b rd=%0d, want BB33DD11 v=1 rd=2",
               rdata1, rvalid1, rdcnt1);
    end
  endtask

  task automatic test_same_cycle();
    we1 = 1; re1 = 1; addr1 = 200; wstrb1 = 4'hF; wdata1 = 32'hDEADBEEF;
    cyc();
    we1 = 0;
    n_checks++;
    if (rdata1 !== 32'h0 || rvalid1 !== 1'b1) begin
      n_fail++;
      $display("FAIL rw_same_cycle_old: got data=%h v=%b, want 00000000 v=1", rdata1, rvalid1);
    end
    cyc();
    re1 = 0;
    n_checks++;
    if (rdata1 !== 32'hDEADBEEF || wrcnt1 !== 32'd2 || rdcnt1 !== 32'd4) begin
      n_fail++;
      $display("FAIL rw_next_cycle_new: got data=%h wr=%0d rd=%0d, want DEADBEEF wr=2 rd=4",
               rdata1, wrcnt1, rdcnt1);
    end
  endtask

  task automatic test_oob();
    logic [23:0] tail;
    we1 = 1; addr1 = 19998; wstrb1 = 4'hF; wdata1 = 32'h01020304;
    cyc();
    we1 = 0;
    tail = {dut.mem[20000], dut.mem[19999], dut.mem[19998]};
    n_checks++;
    if (err1 !== 1'b1 || wrcnt1 !== 32'd2 || tail !== 24'h5C5B5A) begin
      n_fail++;
      $display("FAIL oob_write: got err=%b wr=%0d tail=%h, want err=1 wr=2 tail=5C5B5A",
               err1, wrcnt1, tail);
    end
    re1 = 1; addr1 = 19997;
    cyc();
    n_checks++;
    if (rdata1 !== 32'h5C5B5A59 || rvalid1 !== 1'b1 || rdcnt1 !== 32'd5 || err1 !== 1'b1) begin
      n_fail++;
      $display("FAIL edge_read: got data=%h v=%b rd=%0d err=%b, want 5C5B5A59 v=1 rd=5 err=1",
               rdata1, rvalid1, rdcnt1, err1);
    end
    addr1 = 19998;
    cyc();
    re1 = 0;
    n_checks++;
    if (rdata1 !== 32'h0 || rvalid1 !== 1'b1 || rdcnt1 !== 32'd5) begin
      n_fail++;
      $display("FAIL oob_read: got data=%h v=%b rd=%0d, want 00000000 v=1 rd=5",
               rdata1, rvalid1, rdcnt1);
    end
  endtask

  task automatic test_reset_write();
    rst = 1; we1 = 1; addr1 = 300; wstrb1 = 4'hF; wdata1 = 32'h12345678;
    cyc();
    rst = 0; we1 = 0;
    n_checks++;
    if (wrcnt1 !== 32'd0 || rdcnt1 !== 32'd0 || err1 !== 1'b0 || rvalid1 !== 1'b0 || rdata1 !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_clears: got wr=%0d rd=%0d err=%b v=%b data=%h, want all zero",
               wrcnt1, rdcnt1, err1, rvalid1, rdata1);
    end
    re1 = 1; addr1 = 300;
    cyc();
    addr1 = 100;
    n_checks++;
    if (rdata1 !== 32'h0 || rvalid1 !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_write_ignored: got data=%h v=%b, want 00000000 v=1", rdata1, rvalid1);
    end
    cyc();
    re1 = 0;
    n_checks++;
    if (rdata1 !== 32'hBB33DD11) begin
      n_fail++;
      $display("FAIL mem_survives_reset: got %h, want BB33DD11", rdata1);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp [0:2];
    exp[0] = 32'h04030201; exp[1] = 32'h08070605; exp[2] = 32'h0C0B0A09;
    for (int k = 0; k < 6; k++) begin
      re3 = (k < 3);
      addr3 = 32'(4 * k);
      cyc();
      n_checks++;
      if (k >= 2 && k <= 4) begin
        if (rvalid3 !== 1'b1 || rdata3 !== exp[k-2]) begin
          n_fail++;
          $display("FAIL b2b_edge%0d: got v=%b data=%h, want v=1 data=%h", k, rvalid3, rdata3, exp[k-2]);
        end
      end else if (k == 5) begin
        if (rvalid3 !== 1'b0 || rdata3 !== exp[2]) begin
          n_fail++;
          $display("FAIL b2b_tail: got v=%b data=%h, want v=0 data=%h", rvalid3, rdata3, exp[2]);
        end
      end else begin
        if (rvalid3 !== 1'b0) begin
          n_fail++;
          $display("FAIL b2b_latency_edge%0d: got v=%b, want 0", k, rvalid3);
        end
      end
    end
    re3 = 0;
    n_checks++;
    if (rdcnt3 !== 32'd3) begin
      n_fail++;
      $display("FAIL b2b_rd_count: got %0d, want 3", rdcnt3);
    end
  endtask

  task automatic test_reset_midflight();
    logic seen;
    re3 = 1; addr3 = 4;
    cyc();
    addr3 = 19999;
    cyc();
    re3 = 0;
    n_checks++;
    if (err3 !== 1'b1) begin
      n_fail++;
      $display("FAIL midflight_oob_err: got %b, want 1", err3);
    end
    rst = 1;
    cyc();
    rst = 0;
    n_checks++;
    if (rvalid3 !== 1'b0 || err3 !== 1'b0 || rdcnt3 !== 32'd0 || wrcnt3 !== 32'd0) begin
      n_fail++;
      $display("FAIL midflight_reset: got v=%b err=%b rd=%0d wr=%0d, want all zero",
               rvalid3, err3, rdcnt3, wrcnt3);
    end
    seen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cyc();
      if (rvalid3 === 1'b1) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL midflight_no_valid: got valid pulse %b, want 0", seen);
    end
    re3 = 1; addr3 = 0;
    cyc();
    re3 = 0;
    cyc(); cyc();
    n_checks++;
    if (rvalid3 !== 1'b1 || rdata3 !== 32'h04030201) begin
      n_fail++;
      $display("FAIL midflight_mem_intact: got v=%b data=%h, want v=1 data=04030201", rvalid3, rdata3);
    end
  endtask

  initial begin
    preload();
    test_reset();
    test_read();
    test_strobe_write();
    test_same_cycle();
    test_oob();
    test_reset_write();
    test_back_to_back();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
